// File: rtl/sng_pkg.sv
// Shared types and constants for the stochastic number generator.
package sng_pkg;

    // Stream controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Maximal-length feedback masks for a shift-left Fibonacci LFSR,
    // next = {r[N-2:0], ^(r & mask)}.
    localparam logic [7:0] TAPS_4 = 8'b0000_1100; // x^4+x^3+1
    localparam logic [7:0] TAPS_5 = 8'b0001_0100; // x^5+x^3+1
    localparam logic [7:0] TAPS_6 = 8'b0011_0000; // x^6+x^5+1
    localparam logic [7:0] TAPS_7 = 8'b0110_0000; // x^7+x^6+1
    localparam logic [7:0] TAPS_8 = 8'b1011_1000; // x^8+x^6+x^5+x^4+1

    // Feedback mask for a given LFSR width.
    function automatic logic [7:0] tap_mask(input int unsigned nb);
        logic [7:0] m;
        case (nb)
            5:       m = TAPS_5;
            6:       m = TAPS_6;
            7:       m = TAPS_7;
            8:       m = TAPS_8;
            default: m = TAPS_4;
        endcase
        return m;
    endfunction

    // Per-lane seed; distinct and never zero.
    function automatic int unsigned seed(input int unsigned i);
        return i + 1;
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// One lane's maximal-length Fibonacci LFSR with synchronous reload.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int unsigned NUM_BIT = 4,
    parameter int unsigned SEED    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    output logic [NUM_BIT-1:0] q
);

    localparam logic [7:0]         TAPS_FULL = tap_mask(NUM_BIT);
    localparam logic [NUM_BIT-1:0] TAPS      = TAPS_FULL[NUM_BIT-1:0];
    localparam logic [NUM_BIT-1:0] SEED_V    = SEED[NUM_BIT-1:0];

    logic feedback;

    // XOR of the tapped bits feeds the vacated LSB.
    always_comb begin
        feedback = ^(q & TAPS);
    end

    // Reload to the seed on request, otherwise shift when stepped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED_V;
        end else if (load) begin
            q <= SEED_V;
        end else if (step) begin
            q <= {q[NUM_BIT-2:0], feedback};
        end
    end

endmodule

// File: rtl/sng_stream.sv
// Binary-to-stochastic encoder: DIM lanes of LFSR + comparator under a
// start/stall/done stream controller.
module sng_stream
    import sng_pkg::*;
#(
    parameter int unsigned NUM_BIT = 4,
    parameter int unsigned DIM     = 4
) (
    input  logic                   i_clk_sng,
    input  logic                   i_rst_sng,
    input  logic                   i_start_sng,
    input  logic                   i_stall_sng,
    input  logic [NUM_BIT-1:0]     i_len_sng,
    input  logic [NUM_BIT*DIM-1:0] i_x_sng,
    output logic                   o_busy_sng,
    output logic                   o_valid_sng,
    output logic [DIM-1:0]         o_sn_bit_sng,
    output logic                   o_done_sng
);

    localparam logic [NUM_BIT-1:0] FULL_LEN = '1;

    state_t                 state_r;
    state_t                 state_nxt;
    logic [NUM_BIT*DIM-1:0] x_r;
    logic [NUM_BIT-1:0]     len_r;
    logic [NUM_BIT-1:0]     cnt_r;
    logic [NUM_BIT*DIM-1:0] lfsr_q;
    logic                   lfsr_load;
    logic                   lfsr_step;
    logic                   last_beat;

    // Final beat of the stream: the counter has reached L-1.
    always_comb begin
        last_beat = (cnt_r == (len_r - NUM_BIT'(1)));
    end

    // State register.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and handshake outputs; stall only matters in STREAM.
    always_comb begin
        state_nxt   = state_r;
        o_busy_sng  = 1'b0;
        o_valid_sng = 1'b0;
        o_done_sng  = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start_sng) begin
                    lfsr_load = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                o_busy_sng = 1'b1;
                if (!i_stall_sng) begin
                    o_valid_sng = 1'b1;
                    lfsr_step   = 1'b1;
                    if (last_beat) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                o_busy_sng = 1'b1;
                o_done_sng = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/length capture at start and the beat counter.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            x_r   <= '0;
            len_r <= '0;
            cnt_r <= '0;
        end else if (lfsr_load) begin
            x_r   <= i_x_sng;
            len_r <= (i_len_sng == '0) ? FULL_LEN : i_len_sng;
            cnt_r <= '0;
        end else if (lfsr_step) begin
            cnt_r <= cnt_r + NUM_BIT'(1);
        end
    end

    // One LFSR per lane, each with its own seed.
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        sng_lfsr #(
            .NUM_BIT (NUM_BIT),
            .SEED    (seed(g))
        ) u_lfsr (
            .clk  (i_clk_sng),
            .rst  (i_rst_sng),
            .load (lfsr_load),
            .step (lfsr_step),
            .q    (lfsr_q[g*NUM_BIT +: NUM_BIT])
        );
    end

    // Comparator: a lane emits 1 when its operand is at least its LFSR value.
    always_comb begin
        o_sn_bit_sng = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            o_sn_bit_sng[i] = o_valid_sng &&
                (x_r[i*NUM_BIT +: NUM_BIT] >= lfsr_q[i*NUM_BIT +: NUM_BIT]);
        end
    end

endmodule
